imem_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer placed between the PC/branch logic and InstructionMemory.
//  - Generates word-aligned fetch addresses for the memory.
//  - Absorbs the memory's 1-cycle synchronous read latency.
//  - Buffers fetched words with their PCs in a small prefetch queue.
//  - Hands words to the IF/ID stage over a valid/ready handshake.
//  - Flushes the queue and any in-flight read when a branch/jump redirect arrives.

---
 rtl/imem_fetch_ctrl_pkg.sv | 28 ++
 rtl/imem_fetch_ctrl_fifo.sv | 63 ++++++
 rtl/imem_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   INST_W        instruction / address width
//   PC_STEP       byte increment between consecutive fetches
//   RESET_PC_DEF  default fetch PC after reset
//   fetch_state_e controller FSM encoding
//   fetch_entry_t one prefetch-queue entry {pc, inst}
//   align_word()  clears the two byte-offset bits of an address
package imem_fetch_ctrl_pkg;

    localparam int          INST_W       = 32;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [INST_W-1:0] align_word(input logic [INST_W-1:0] addr);
        return {addr[INST_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, inst} entries.
// Ports:
//   Clk, Rst_n     clock, synchronous active-low reset
//   i_push         write i_entry at the tail
//   i_entry        {pc, inst} to store
//   i_pop          advance the head (caller guarantees non-empty)
//   i_flush        empty the queue; dominates push and pop
//   o_head         entry at the head
//   o_count        number of stored entries (0..DEPTH)
module imem_fetch_ctrl_fifo
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       i_push,
    input  fetch_entry_t               i_entry,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // Storage needs no reset: entries are only visible while r_count covers them.
    always_ff @(posedge Clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer between PC/branch logic and InstructionMemory.
// Issues word-aligned reads, absorbs the memory's 1-cycle read latency,
// buffers returned words with their PCs and hands them to IF/ID via valid/ready.
// Ports:
//   Clk, Rst_n   clock, synchronous active-low reset
//   Enable       1 = issue fetches, 0 = stop issuing and drain
//   Redirect     1-cycle pulse: flush queue and in-flight read, refetch from RedirectPC
//   RedirectPC   new fetch byte address (low 2 bits ignored)
//   ImemAddr     read address to InstructionMemory (always the fetch PC)
//   ImemInst     read data, valid the cycle after an issue
//   Out_Valid    head of queue holds an instruction
//   Out_Ready    IF/ID accepts the head this cycle
//   Out_Inst     head instruction (0 when empty)
//   Out_PC       byte address of Out_Inst (0 when empty)
//   Busy         queue non-empty or a read is in flight
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Enable,
    input  logic              Redirect,
    input  logic [INST_W-1:0] RedirectPC,
    output logic [INST_W-1:0] ImemAddr,
    input  logic [INST_W-1:0] ImemInst,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [INST_W-1:0] Out_Inst,
    output logic [INST_W-1:0] Out_PC,
    output logic              Busy
);

    localparam int                 CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]     DEPTH_L = (CNT_W + 1)'(DEPTH);

    fetch_state_e       r_state;
    fetch_state_e       w_next_state;
    logic [INST_W-1:0]  r_fetch_pc;
    logic               r_inflight;
    logic [INST_W-1:0]  r_inflight_pc;

    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W:0]     w_used;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; Redirect deliberately has no effect on the state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (Enable)  w_next_state = FETCH;
            FETCH:   if (!Enable) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Issue decision. Counting the in-flight read against the queue depth
    // reserves its slot, so a returning word always finds room.
    always_comb begin
        w_used  = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
        w_issue = (r_state == FETCH) && !Redirect && (w_used < DEPTH_L);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            if (Redirect) begin
                r_fetch_pc <= align_word(RedirectPC);
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    // A redirect in the return cycle kills the stale word.
    assign w_push            = r_inflight && !Redirect;
    assign w_pop             = Out_Valid && Out_Ready;
    assign w_push_entry.pc   = r_inflight_pc;
    assign w_push_entry.inst = ImemInst;

    imem_fetch_ctrl_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (Redirect),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign ImemAddr  = r_fetch_pc;
    assign Out_Valid = (w_count != '0);
    assign Out_Inst  = Out_Valid ? w_head.inst : '0;
    assign Out_PC    = Out_Valid ? w_head.pc   : '0;
    assign Busy      = Out_Valid || r_inflight;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Enable;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] ImemAddr;
    logic [31:0] ImemInst;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Inst;
    logic [31:0] Out_PC;
    logic        Busy;

    int n_cmp = 0;
    int n_err = 0;

    imem_fetch_ctrl #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Enable     (Enable),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .ImemAddr   (ImemAddr),
        .ImemInst   (ImemInst),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Out_Inst   (Out_Inst),
        .Out_PC     (Out_PC),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    // Synchronous instruction memory: m[i] = i + 100
    always @(posedge Clk) begin
        ImemInst <= (ImemAddr >> 2) + 32'd100;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle reset; returns in cycle 0 with reset released, state IDLE.
    task automatic do_reset();
        Rst_n = 1'b0;
        tick(1);
        Rst_n = 1'b1;
    endtask

    initial begin
        Rst_n      = 1'b0;
        Enable     = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = 32'h0;
        Out_Ready  = 1'b0;

        // Reset values
        tick(2);
        chk("rst_valid", {31'b0, Out_Valid}, 32'd0);
        chk("rst_busy",  {31'b0, Busy},      32'd0);
        chk("rst_addr",  ImemAddr,           32'h0);
        chk("rst_inst",  Out_Inst,           32'h0);
        chk("rst_pc",    Out_PC,             32'h0);
        Rst_n = 1'b1;

        // 1: streaming, first word at cycle 3, then one per cycle
        Enable    = 1'b1;
        Out_Ready = 1'b1;
        tick(1);
        chk("t1_valid_c1", {31'b0, Out_Valid}, 32'd0);
        chk("t1_addr_c1",  ImemAddr,           32'h0);
        tick(1);
        chk("t1_valid_c2", {31'b0, Out_Valid}, 32'd0);
        tick(1);
        chk("t1_valid_c3", {31'b0, Out_Valid}, 32'd1);
        chk("t1_pc_c3",    Out_PC,             32'h0);
        chk("t1_inst_c3",  Out_Inst,           32'd100);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk("t1_valid", {31'b0, Out_Valid}, 32'd1);
            chk("t1_pc",    Out_PC,             32'(4 * i));
            chk("t1_inst",  Out_Inst,           32'(100 + i));
        end

        // 2: backpressure fills the queue, then release drains in order
        Enable    = 1'b0;
        Out_Ready = 1'b0;
        do_reset();
        Enable = 1'b1;
        tick(5);
        chk("t2_addr_c5", ImemAddr,        32'h10);
        chk("t2_busy_c5", {31'b0, Busy},   32'd1);
        tick(1);
        chk("t2_addr_c6", ImemAddr,        32'h10);
        chk("t2_pc_c6",   Out_PC,          32'h0);
        chk("t2_inst_c6", Out_Inst,        32'd100);
        tick(5);
        chk("t2_addr_c11",  ImemAddr,           32'h10);
        chk("t2_valid_c11", {31'b0, Out_Valid}, 32'd1);
        chk("t2_inst_c11",  Out_Inst,           32'd100);
        Out_Ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            chk("t2_drain_valid", {31'b0, Out_Valid}, 32'd1);
            chk("t2_drain_pc",    Out_PC,             32'(4 * i));
            chk("t2_drain_inst",  Out_Inst,           32'(100 + i));
            tick(1);
        end

        // 3: redirect to 0x43 while a read is in flight
        Enable    = 1'b0;
        Out_Ready = 1'b1;
        do_reset();
        Enable = 1'b1;
        tick(2);
        chk("t3_busy_c2", {31'b0, Busy}, 32'd1);
        Redirect   = 1'b1;
        RedirectPC = 32'h43;
        tick(1);
        Redirect = 1'b0;
        chk("t3_valid_r1", {31'b0, Out_Valid}, 32'd0);
        chk("t3_addr_r1",  ImemAddr,           32'h40);
        tick(1);
        chk("t3_valid_r2", {31'b0, Out_Valid}, 32'd0);
        tick(1);
        chk("t3_valid_r3", {31'b0, Out_Valid}, 32'd1);
        chk("t3_pc_r3",    Out_PC,             32'h40);
        chk("t3_inst_r3",  Out_Inst,           32'd116);
        tick(1);
        chk("t3_pc_r4",    Out_PC,             32'h44);
        chk("t3_inst_r4",  Out_Inst,           32'd117);

        // 4: redirect in a cycle with both pop and push
        Enable = 1'b0;
        do_reset();
        Enable = 1'b1;
        tick(3);
        chk("t4_pc_c3", Out_PC, 32'h0);
        Redirect   = 1'b1;
        RedirectPC = 32'h80;
        tick(1);
        Redirect = 1'b0;
        chk("t4_valid_r1", {31'b0, Out_Valid}, 32'd0);
        chk("t4_busy_r1",  {31'b0, Busy},      32'd0);
        chk("t4_addr_r1",  ImemAddr,           32'h80);
        tick(1);
        chk("t4_valid_r2", {31'b0, Out_Valid}, 32'd0);
        chk("t4_busy_r2",  {31'b0, Busy},      32'd1);
        tick(1);
        chk("t4_pc_r3",    Out_PC,   32'h80);
        chk("t4_inst_r3",  Out_Inst, 32'd132);

        // 5: redirect in IDLE near the top of the address space, then wrap
        Enable = 1'b0;
        do_reset();
        Redirect   = 1'b1;
        RedirectPC = 32'hFFFF_FFF8;
        tick(1);
        Redirect = 1'b0;
        chk("t5_addr_idle",  ImemAddr,           32'hFFFF_FFF8);
        chk("t5_valid_idle", {31'b0, Out_Valid}, 32'd0);
        chk("t5_busy_idle",  {31'b0, Busy},      32'd0);
        Enable = 1'b1;
        tick(3);
        chk("t5_pc_0",   Out_PC,   32'hFFFF_FFF8);
        chk("t5_inst_0", Out_Inst, 32'h4000_0062);
        tick(1);
        chk("t5_pc_1",   Out_PC,   32'hFFFF_FFFC);
        chk("t5_inst_1", Out_Inst, 32'h4000_0063);
        tick(1);
        chk("t5_pc_2",   Out_PC,   32'h0000_0000);
        chk("t5_inst_2", Out_Inst, 32'd100);

        // 6: reset mid-stream with three words queued and one in flight
        Enable    = 1'b0;
        Out_Ready = 1'b0;
        do_reset();
        Enable = 1'b1;
        tick(5);
        chk("t6_valid_pre", {31'b0, Out_Valid}, 32'd1);
        chk("t6_busy_pre",  {31'b0, Busy},      32'd1);
        Rst_n = 1'b0;
        tick(1);
        chk("t6_valid", {31'b0, Out_Valid}, 32'd0);
        chk("t6_busy",  {31'b0, Busy},      32'd0);
        chk("t6_addr",  ImemAddr,           32'h0);
        chk("t6_pc",    Out_PC,             32'h0);
        chk("t6_inst",  Out_Inst,           32'h0);
        Rst_n     = 1'b1;
        Enable    = 1'b0;
        Out_Ready = 1'b1;
        tick(2);
        chk("t6_valid_after", {31'b0, Out_Valid}, 32'd0);
        chk("t6_busy_after",  {31'b0, Busy},      32'd0);
        chk("t6_addr_after",  ImemAddr,           32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
